mpmc10_resp_fifo128_fta: RTL and testbench

//  Response-side buffer for one mpmc10 channel. Accepts fta_cmd_response128_t beats

---
 rtl/mpmc10_resp_fifo128_fta.sv | 157 +++++++++++++++
 tb/tb_mpmc10_resp_fifo128_fta.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mpmc10_resp_fifo128_fta.sv
// mpmc10_resp_fifo128_fta
//    Response-side buffer for one mpmc10 channel. Response beats arriving from the
//    memory-controller read/ack path are held in strict arrival order and handed back
//    to the requester through a registered head with a pop handshake.
//
//    Storage is a (DEPTH-1)-entry ring plus the output register, DEPTH beats in total.
//    The response structure is carried as flat fields (ack, tid, dat). tid and dat are
//    passed through unmodified.
//
// Ports
//    clk_i      clock, all logic on rising edge
//    rst_i      synchronous reset, active-high; discards every held beat
//    i_ack_i    incoming beat valid (push request)
//    i_tid_i    incoming beat transaction id
//    i_dat_i    incoming beat data
//    rd_i       consumer pops the head (ignored while o_ack_o=0)
//    o_ack_o    head valid (registered)
//    o_tid_o    head transaction id (registered)
//    o_dat_o    head data (registered)
//    empty_o    no beats held anywhere
//    full_o     count_o == DEPTH
//    afull_o    count_o >= AFULL
//    count_o    beats held, including the output register
//    ovf_o      sticky: a push was dropped because the buffer was full
module mpmc10_resp_fifo128_fta #(
   parameter int DEPTH = 16,
   parameter int AFULL = 12,
   parameter int TID_W = 13,
   parameter int DAT_W = 128
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     i_ack_i,
   input  logic [TID_W-1:0]         i_tid_i,
   input  logic [DAT_W-1:0]         i_dat_i,
   input  logic                     rd_i,
   output logic                     o_ack_o,
   output logic [TID_W-1:0]         o_tid_o,
   output logic [DAT_W-1:0]         o_dat_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic                     afull_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     ovf_o
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int PAY_W = TID_W + DAT_W;

   // Ring slots run 0..DEPTH-2, so the pointer wraps explicitly at DEPTH-2.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PW'(DEPTH - 2)) begin
         r = {PW{1'b0}};
      end else begin
         r = p + PW'(1);
      end
      return r;
   endfunction

   logic [PAY_W-1:0] mem_q [DEPTH-1];

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    rcnt_q, rcnt_d;
   logic [CW-1:0]    count_q, count_d;
   logic             o_ack_q, o_ack_d;
   logic [TID_W-1:0] o_tid_q, o_tid_d;
   logic [DAT_W-1:0] o_dat_q, o_dat_d;
   logic             empty_q, full_q, afull_q;
   logic             ovf_q, ovf_d;

   logic pop_s, push_s, load_s, ring_empty_s, ring_rd_s, ring_wr_s;

   // Handshake decode, head-register refill selection and next-state computation.
   always_comb begin
      pop_s        = rd_i & o_ack_q;
      // A pop in the same cycle frees a slot, so a push is legal even when full.
      push_s       = i_ack_i & (~full_q | pop_s);
      load_s       = ~o_ack_q | pop_s;
      ring_empty_s = (rcnt_q == {PW{1'b0}});
      ring_rd_s    = load_s & ~ring_empty_s;
      // With an empty ring, a push into a vacant head bypasses the ring entirely.
      ring_wr_s    = push_s & ~(load_s & ring_empty_s);

      o_ack_d = o_ack_q;
      o_tid_d = o_tid_q;
      o_dat_d = o_dat_q;
      if (load_s) begin
         if (!ring_empty_s) begin
            o_ack_d            = 1'b1;
            {o_tid_d, o_dat_d} = mem_q[rptr_q];
         end else if (push_s) begin
            o_ack_d = 1'b1;
            o_tid_d = i_tid_i;
            o_dat_d = i_dat_i;
         end else begin
            o_ack_d = 1'b0;
         end
      end else begin
         o_ack_d = o_ack_q;
      end

      wptr_d  = ring_wr_s ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = ring_rd_s ? ptr_inc(rptr_q) : rptr_q;
      rcnt_d  = rcnt_q + PW'(ring_wr_s) - PW'(ring_rd_s);
      count_d = count_q + CW'(push_s) - CW'(pop_s);
      ovf_d   = ovf_q | (i_ack_i & full_q & ~pop_s);
   end

   // Ring storage; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk_i) begin
      if (ring_wr_s) begin
         mem_q[wptr_q] <= {i_tid_i, i_dat_i};
      end
   end

   // State and registered status; flags are derived from the next count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= {PW{1'b0}};
         rptr_q  <= {PW{1'b0}};
         rcnt_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
         o_ack_q <= 1'b0;
         o_tid_q <= {TID_W{1'b0}};
         o_dat_q <= {DAT_W{1'b0}};
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         rcnt_q  <= rcnt_d;
         count_q <= count_d;
         o_ack_q <= o_ack_d;
         o_tid_q <= o_tid_d;
         o_dat_q <= o_dat_d;
         empty_q <= (count_d == {CW{1'b0}});
         full_q  <= (count_d == CW'(DEPTH));
         afull_q <= (count_d >= CW'(AFULL));
         ovf_q   <= ovf_d;
      end
   end

   assign o_ack_o = o_ack_q;
   assign o_tid_o = o_tid_q;
   assign o_dat_o = o_dat_q;
   assign empty_o = empty_q;
   assign full_o  = full_q;
   assign afull_o = afull_q;
   assign count_o = count_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_mpmc10_resp_fifo128_fta.sv
// Testbench for mpmc10_resp_fifo128_fta: directed steps plus random traffic,
// checked against a queue-based reference of the response buffer.
module tb_mpmc10_resp_fifo128_fta;

   localparam int DEPTH = 16;
   localparam int AFULL = 12;
   localparam int TID_W = 13;
   localparam int DAT_W = 128;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             i_ack_i;
   logic [TID_W-1:0] i_tid_i;
   logic [DAT_W-1:0] i_dat_i;
   logic             rd_i;
   logic             o_ack_o;
   logic [TID_W-1:0] o_tid_o;
   logic [DAT_W-1:0] o_dat_o;
   logic             empty_o;
   logic             full_o;
   logic             afull_o;
   logic [CW-1:0]    count_o;
   logic             ovf_o;

   always #5 clk_i = ~clk_i;

   mpmc10_resp_fifo128_fta #(
      .DEPTH(DEPTH), .AFULL(AFULL), .TID_W(TID_W), .DAT_W(DAT_W)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_ack_i(i_ack_i),
      .i_tid_i(i_tid_i),
      .i_dat_i(i_dat_i),
      .rd_i   (rd_i),
      .o_ack_o(o_ack_o),
      .o_tid_o(o_tid_o),
      .o_dat_o(o_dat_o),
      .empty_o(empty_o),
      .full_o (full_o),
      .afull_o(afull_o),
      .count_o(count_o),
      .ovf_o  (ovf_o)
   );

   typedef struct packed {
      logic [TID_W-1:0] tid;
      logic [DAT_W-1:0] dat;
   } beat_t;

   beat_t mq[$];
   bit    m_ovf;
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic chk(input string tag, input logic [DAT_W-1:0] obs, input logic [DAT_W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("o_ack", DAT_W'(o_ack_o), DAT_W'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("o_tid", DAT_W'(o_tid_o), DAT_W'(mq[0].tid));
         chk("o_dat", o_dat_o, mq[0].dat);
      end
      chk("count", DAT_W'(count_o), DAT_W'(mq.size()));
      chk("empty", DAT_W'(empty_o), DAT_W'(mq.size() == 0));
      chk("full",  DAT_W'(full_o),  DAT_W'(mq.size() == DEPTH));
      chk("afull", DAT_W'(afull_o), DAT_W'(mq.size() >= AFULL));
      chk("ovf",   DAT_W'(ovf_o),   DAT_W'(m_ovf));
   endtask

   // One clock: drive inputs, advance the reference at the edge, compare after it.
   task automatic step(input bit ack, input logic [TID_W-1:0] tid,
                       input logic [DAT_W-1:0] dat, input bit rd);
      bit    pop, push;
      beat_t b;
      rst_i   = 1'b0;
      i_ack_i = ack;
      i_tid_i = tid;
      i_dat_i = dat;
      rd_i    = rd;
      @(posedge clk_i);
      pop  = rd && (mq.size() > 0);
      push = ack && ((mq.size() < DEPTH) || pop);
      if (ack && !push) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) begin
         b.tid = tid;
         b.dat = dat;
         mq.push_back(b);
      end
      #1;
      check_all();
   endtask

   task automatic do_reset(input int n);
      rst_i   = 1'b1;
      i_ack_i = 1'b0;
      i_tid_i = '0;
      i_dat_i = '0;
      rd_i    = 1'b0;
      repeat (n) @(posedge clk_i);
      mq.delete();
      m_ovf = 1'b0;
      #1;
      rst_i = 1'b0;
      check_all();
   endtask

   function automatic logic [DAT_W-1:0] rdat();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      rst_i   = 1'b1;
      i_ack_i = 1'b0;
      i_tid_i = '0;
      i_dat_i = '0;
      rd_i    = 1'b0;
      m_ovf   = 1'b0;

      // Reset then idle.
      do_reset(2);
      step(1'b0, '0, '0, 1'b0);

      // Single beat: visible one edge after push, then popped.
      step(1'b1, TID_W'(5), {16{8'hA5}}, 1'b0);
      step(1'b0, '0, '0, 1'b1);

      // Fill to full, overflow one beat, drain in order.
      for (int k = 0; k < DEPTH; k++) step(1'b1, TID_W'(k), rdat(), 1'b0);
      step(1'b1, TID_W'(99), rdat(), 1'b0);
      for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, 1'b1);

      // Push and pop together while full: count holds, no overflow, new beat last.
      do_reset(1);
      for (int k = 0; k < DEPTH; k++) step(1'b1, TID_W'(k), rdat(), 1'b0);
      step(1'b1, TID_W'(20), rdat(), 1'b1);
      for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, 1'b1);

      // Continuous streaming with random beats.
      for (int k = 0; k < 100; k++) step(1'b1, TID_W'($urandom), rdat(), 1'b1);
      step(1'b0, '0, '0, 1'b1);

      // Reset while holding beats, then a fresh push.
      for (int k = 0; k < 7; k++) step(1'b1, TID_W'(k + 40), rdat(), 1'b0);
      do_reset(1);
      step(1'b1, TID_W'(3), rdat(), 1'b0);

      // Random traffic, biased towards pushes to reach full and overflow.
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 9) < 6), TID_W'($urandom), rdat(),
              ($urandom_range(0, 9) < ((k / 100) % 2 == 0 ? 3 : 7)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
